// File: rtl/lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_ctrl : load/store control in front of a byte-addressed data memory;  |
// |            sub-word stores use read-modify-write. Option: LSU_ALIGN_CHECK_EN |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lsu_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wd,
  input  logic [31:0]           mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;
  localparam logic [1:0] c_SZ_BAD  = 2'b11;
  localparam logic [ADDR_WIDTH:0] c_MEM_BYTES = (ADDR_WIDTH+1)'(MEM_BYTES);
  localparam logic [ADDR_WIDTH:0] c_WORD_SPAN = (ADDR_WIDTH+1)'(4);

  state_t                  r_state, w_next;
  logic                    r_we, r_signed, r_err;
  logic [1:0]              r_size;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [31:0]             r_wdata, r_merge, r_rdata;
  logic [31:0]             w_load_ext;
  logic                    w_range_err, w_align_err, w_req_err;

  // Range check covers the full 4-byte read footprint; one extra bit avoids wrap.
  assign w_range_err = (({1'b0, req_addr} + c_WORD_SPAN) > c_MEM_BYTES);

`ifdef LSU_ALIGN_CHECK_EN
  assign w_align_err = ((req_size == c_SZ_HALF) && req_addr[0]) ||
                       ((req_size == c_SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign w_align_err = 1'b0;
`endif

  assign w_req_err = (req_size == c_SZ_BAD) || w_range_err || w_align_err;

  always_comb begin
    case (r_size)
      c_SZ_BYTE: w_load_ext = {{24{r_signed & mem_rd[7]}}, mem_rd[7:0]};
      c_SZ_HALF: w_load_ext = {{16{r_signed & mem_rd[15]}}, mem_rd[15:0]};
      default:   w_load_ext = mem_rd;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_wd    = 32'h0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)                  w_next = S_RESP;
          else if (!req_we)               w_next = S_LOAD;
          else if (req_size == c_SZ_WORD) w_next = S_WRITE;
          else                            w_next = S_RMW_RD;
        end
      end
      S_LOAD:   w_next = S_RESP;
      S_RMW_RD: w_next = S_WRITE;
      S_WRITE: begin
        mem_we = 1'b1;
        mem_wd = (r_size == c_SZ_WORD) ? r_wdata : r_merge;
        w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_merge  <= 32'h0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= 32'h0;
            r_err    <= w_req_err;
          end
        end
        S_LOAD:   r_rdata <= r_we ? 32'h0 : w_load_ext;
        S_RMW_RD: begin
          if (r_size == c_SZ_BYTE) r_merge <= {mem_rd[31:8], r_wdata[7:0]};
          else                     r_merge <= {mem_rd[31:16], r_wdata[15:0]};
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lsu_ctrl : scoreboard bench for lsu_ctrl with a byte-array memory.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_lsu_ctrl;
  localparam int AW = 32;
  localparam int MB = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wd, mem_rd;

  lsu_ctrl #(.ADDR_WIDTH(AW), .MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          pulses;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem[MB];
  logic [7:0]  model[MB];
  int          we_cnt = 0;
  int          wd_leak = 0;
  logic [31:0] last_wd = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  always_comb begin
    mem_rd = 32'h0;
    for (int i = 0; i < 4; i++)
      if (int'(mem_addr) + i < MB) mem_rd[8*i +: 8] = mem[int'(mem_addr) + i];
  end

  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt++;
      last_wd = mem_wd;
      for (int i = 0; i < 4; i++)
        if (int'(mem_addr) + i < MB) mem[int'(mem_addr) + i] = mem_wd[8*i +: 8];
    end
  end

  always @(negedge clk) if (!mem_we && mem_wd != 32'h0) wd_leak++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: updates the model memory for stores and returns the expected response.
  task automatic predict(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    logic [31:0] w;
    logic        bad;
    bad = (size == 2'b11) || (addr > 32'(MB - 4));
`ifdef LSU_ALIGN_CHECK_EN
    if (size == 2'b01 && addr[0]) bad = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) bad = 1'b1;
`endif
    e.rdata = 32'h0; e.err = bad; e.pulses = 0; e.lat = 1;
    if (!bad && !we) begin
      e.lat = 2;
      w = {model[addr+3], model[addr+2], model[addr+1], model[addr]};
      case (size)
        2'b00:   e.rdata = {{24{sgn & w[7]}}, w[7:0]};
        2'b01:   e.rdata = {{16{sgn & w[15]}}, w[15:0]};
        default: e.rdata = w;
      endcase
    end else if (!bad) begin
      e.pulses = 1;
      e.lat = (size == 2'b10) ? 2 : 3;
      model[addr] = wdata[7:0];
      if (size != 2'b00) model[addr+1] = wdata[15:8];
      if (size == 2'b10) begin
        model[addr+2] = wdata[23:16];
        model[addr+3] = wdata[31:24];
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    exp_t e, got;
    int   lat, we0;
    logic [31:0] held_rdata;
    logic        held_err;
    @(negedge clk);
    check_eq("req_ready_idle", req_ready, 1'b1);
    predict(we, size, sgn, addr, wdata, e);
    sb.push_back(e);
    we0 = we_cnt;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = sb.pop_front();
    check_eq("rsp_latency", lat, got.lat);
    check_eq("rsp_valid", rsp_valid, 1'b1);
    check_eq("rsp_rdata", rsp_rdata, got.rdata);
    check_eq("rsp_err", rsp_err, got.err);
    held_rdata = rsp_rdata;
    held_err   = rsp_err;
    // A competing store is offered while the response stalls; it must be ignored.
    if (hold > 0) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0;
      req_wdata = 32'hDEADBEEF;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq("hold_rsp_valid", rsp_valid, 1'b1);
      check_eq("hold_rsp_rdata", rsp_rdata, held_rdata);
      check_eq("hold_rsp_err", rsp_err, held_err);
      check_eq("hold_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("we_pulses", we_cnt - we0, got.pulses);
    check_eq("rsp_valid_drop", rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0;
    for (int i = 0; i < MB; i++) begin
      mem[i]   = 8'(i);
      model[i] = 8'(i);
    end
    mem[8] = 8'h80; model[8] = 8'h80;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = 32'h0; rsp_ready = 1'b0;
    #1;
    check_eq("rst_req_ready", req_ready, 1'b1);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_rsp_err", rsp_err, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wd", mem_wd, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 0);
    do_req(1'b0, 2'b00, 1'b1, 32'd8, 32'h0, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'd8, 32'h0, 0);
    do_req(1'b1, 2'b00, 1'b0, 32'd2, 32'hAABBCCDD, 0);
    check_eq("rmw_byte_wd", last_wd, 32'h050403DD);
    do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'd21, 32'h0, 0);
    do_req(1'b1, 2'b11, 1'b0, 32'd0, 32'h12345678, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'd12, 32'h0, 5);
    do_req(1'b1, 2'b01, 1'b0, 32'd10, 32'h0000F00D, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'd20, 32'hCAFEF00D, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'd10, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'd1, 32'h0, 0);

    // Abort a byte store while it is in its read phase.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd6; req_wdata = 32'h00000011;
    @(negedge clk);
    req_valid = 1'b0;
    we0 = we_cnt;
    check_eq("abort_busy", req_ready, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_eq("abort_req_ready", req_ready, 1'b1);
    check_eq("abort_rsp_valid", rsp_valid, 1'b0);
    check_eq("abort_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("abort_rsp_err", rsp_err, 1'b0);
    check_eq("abort_mem_we", mem_we, 1'b0);
    check_eq("abort_mem_addr", mem_addr, 32'h0);
    check_eq("abort_mem_wd", mem_wd, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    check_eq("abort_no_pulse", we_cnt - we0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 0);

    for (int n = 0; n < 30; n++)
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, MB - 1)), $urandom, 0);

    check_eq("mem_wd_idle_zero", wd_leak, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage that sits directly upstream of the byte-addressed data memory in the pipelined processor's MEM stage.
- Accepts one load or store request at a time from the pipeline over a valid/ready handshake.
- Drives the memory's address, write-enable and write-data ports, and performs read-modify-write for byte and halfword stores.
- Returns a zero- or sign-extended load result, or an error, over a valid/ready response handshake.

Parameters:
- ADDR_WIDTH, 32, width of request and memory addresses.
- MEM_BYTES, 24, number of bytes in the attached memory; used for the range check.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = halfword, 10 = word; 11 is illegal.
- req_signed  input  1  sign-extend load data when 1, zero-extend when 0.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data, taken from the low bits for sub-word stores.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  request rejected; no memory write occurred.
- mem_addr  output  ADDR_WIDTH  to the memory ADDR port.
- mem_we  output  1  to the memory WE port.
- mem_wd  output  32  to the memory WD port, little-endian.
- mem_rd  input  32  from the memory RD port; combinational read of bytes ADDR..ADDR+3.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; req_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_we=0, mem_addr=0, mem_wd=0.
  - All latched request fields cleared.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - req_ready=1. On req_valid=1, latch we, size, signed, addr and wdata.
  - Error check: the request is an error if req_size=11 or if req_addr+4 > MEM_BYTES (full word footprint). On error go to RESP with err=1.
  - Otherwise: a load goes to LOAD; a word store goes to WRITE; a byte or halfword store goes to RMW_RD.
- In every state other than IDLE: req_ready=0.
- LOAD:
  - mem_addr = latched addr; mem_we=0.
  - Capture mem_rd and extend from bit 7 (byte), bit 15 (halfword) or not at all (word), per the latched signed flag, into rsp_rdata.
  - Go to RESP.
- RMW_RD:
  - mem_addr = latched addr; mem_we=0.
  - Capture mem_rd into a merge register.
  - Replace byte 0 (byte store) or bytes 1:0 (halfword store) with the corresponding low bits of wdata.
  - Go to WRITE.
- WRITE:
  - mem_addr = latched addr; mem_we=1 for exactly this one cycle.
  - mem_wd = wdata (word store) or the merge register (sub-word store).
  - Go to RESP.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On rsp_ready=1, go to IDLE and deassert rsp_valid on the next cycle.
- Latency from the accept edge to rsp_valid:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- No new request is accepted in the cycle the response handshake completes; throughput is at most one request per latency+1 cycles.
- mem_we is 0 in every state except WRITE; mem_wd=0 when mem_we=0.
- Reset asserted mid-operation aborts immediately. If reset is asserted during WRITE, the memory may or may not capture that edge. No response is produced for the aborted request.
- Request inputs are ignored outside IDLE; rsp_ready is ignored outside RESP.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- When defined: a halfword with addr[0]=1 or a word with addr[1:0]!=00 is also an error. It goes to RESP with rsp_err=1 and no memory access.
- When undefined: unaligned accesses are legal and use the memory's byte-granular addressing; only the size and range errors apply.

Test Plan:
- Memory preloaded with bytes 0x00..0x17. Word load at addr 4 -> rsp_valid 2 cycles after accept, rsp_rdata=0x07060504, rsp_err=0.
- Byte load addr 8 with memory byte 0x80, req_signed=1 -> 0xFFFFFF80. Same with req_signed=0 -> 0x00000080.
- Byte store addr 2, wdata=0xAABBCCDD:
  - Sequence is RMW_RD then WRITE, with one mem_we pulse and mem_wd = {mem[5],mem[4],mem[3],8'hDD}.
  - A following word load at addr 0 returns byte 2 = 0xDD with the other bytes unchanged.
- Word load addr 21 (MEM_BYTES=24) -> rsp_err=1 one cycle after accept, mem_we never asserted. req_size=11 -> same.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable and req_ready=0 throughout. The next request is accepted only after the handshake.
- Assert reset during RMW_RD -> all outputs return to reset values asynchronously and no mem_we pulse occurs. With LSU_ALIGN_CHECK_EN, a halfword load at addr 1 -> rsp_err=1.
